// File: rtl/seq_alu_param_pkg.sv
// rtl/seq_alu_param_pkg.sv - opcodes, FSM states and flag helpers for seq_alu_param
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_NOR  = 4'b0100;
  localparam logic [3:0] OP_NAND = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b1001;
  localparam logic [3:0] OP_SRL  = 4'b1010;
  localparam logic [3:0] OP_SRA  = 4'b1011;
  localparam logic [3:0] OP_MUL  = 4'b1100;
  localparam logic [3:0] OP_DIVU = 4'b1101;
  localparam logic [3:0] OP_REMU = 4'b1110;
  localparam logic [3:0] OP_ILL  = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Signed overflow of A + Bo, where Bo is B already inverted for SUB.
  function automatic logic add_sub_ovf(input logic a_msb, input logic bo_msb, input logic sum_msb);
    return (a_msb == bo_msb) && (sum_msb != a_msb);
  endfunction

endpackage

// File: rtl/seq_alu_param_if.sv
// rtl/seq_alu_param_if.sv - operand/result handshake bundle for seq_alu_param
interface seq_alu_param_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       ALU_Ctr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] res;
  logic             Co;
  logic             zero;
  logic             overflow;
  logic             illegal;

  modport master (
    output in_valid, A, B, ALU_Ctr, out_ready,
    input  in_ready, out_valid, res, Co, zero, overflow, illegal
  );

  modport slave (
    input  in_valid, A, B, ALU_Ctr, out_ready,
    output in_ready, out_valid, res, Co, zero, overflow, illegal
  );
endinterface

// File: rtl/seq_alu_param_muldiv_iter.sv
// rtl/seq_alu_param_muldiv_iter.sv - iterative shift-add multiplier / restoring divider (ALU_MULDIV_EN only)
`ifdef ALU_MULDIV_EN
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             div0
);
  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0]    cnt_q;
  logic             busy_q, mul_q, rem_q, div0_q;
  // acc: product (MUL) or partial remainder (DIV); y: multiplier or dividend/quotient; x: multiplicand or divisor
  logic [WIDTH-1:0] acc_q, x_q, y_q;
  logic [WIDTH-1:0] acc_d, x_d, y_d;
  logic [WIDTH-1:0] rem_lo, rem_sub;
  logic             rem_ge;

  always_comb begin
    rem_lo  = {acc_q[WIDTH-2:0], y_q[WIDTH-1]};
    rem_sub = rem_lo - x_q;
    // acc_q[msb] set means the shifted remainder already exceeds WIDTH bits, so it beats any divisor
    rem_ge  = acc_q[WIDTH-1] || (rem_lo >= x_q);
    if (mul_q) begin
      acc_d = acc_q + (y_q[0] ? x_q : '0);
      x_d   = x_q << 1;
      y_d   = y_q >> 1;
    end else begin
      acc_d = rem_ge ? rem_sub : rem_lo;
      x_d   = x_q;
      y_d   = {y_q[WIDTH-2:0], rem_ge};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
      mul_q  <= 1'b0;
      rem_q  <= 1'b0;
      div0_q <= 1'b0;
      acc_q  <= '0;
      x_q    <= '0;
      y_q    <= '0;
    end else if (start && !busy_q) begin
      cnt_q  <= CW'(WIDTH - 1);
      busy_q <= 1'b1;
      mul_q  <= (op == OP_MUL);
      rem_q  <= (op == OP_REMU);
      div0_q <= (op != OP_MUL) && (b == '0);
      acc_q  <= '0;
      x_q    <= (op == OP_MUL) ? a : b;
      y_q    <= (op == OP_MUL) ? b : a;
    end else if (busy_q) begin
      acc_q <= acc_d;
      x_q   <= x_d;
      y_q   <= y_d;
      if (cnt_q == '0) busy_q <= 1'b0;
      else             cnt_q  <= cnt_q - 1'b1;
    end
  end

  // The final step's next-state value is handed out directly so the top can register it on the same edge.
  assign busy   = busy_q;
  assign done   = busy_q && (cnt_q == '0);
  assign result = (mul_q || rem_q) ? acc_d : y_d;
  assign div0   = div0_q;

endmodule
`endif

// File: rtl/seq_alu_param.sv
// rtl/seq_alu_param.sv - handshaked parametrised ALU; iterative MUL/DIVU/REMU under ALU_MULDIV_EN
module seq_alu_param
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  seq_alu_param_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             co_q, co_d, zero_q, zero_d, ovf_q, ovf_d, ill_q, ill_d;

  logic             accept, is_md, sub;
  logic [WIDTH-1:0] bo, sum, alu_res;
  logic             carry, alu_co, alu_ovf, alu_ill;
  logic [SHW-1:0]   amt;

  assign accept = bus.in_valid && (state_q == S_IDLE);

`ifdef ALU_MULDIV_EN
  logic             md_busy, md_done, md_div0;
  logic [WIDTH-1:0] md_result;

  assign is_md = (bus.ALU_Ctr == OP_MUL) || (bus.ALU_Ctr == OP_DIVU) || (bus.ALU_Ctr == OP_REMU);

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (accept && is_md),
    .op     (bus.ALU_Ctr),
    .a      (bus.A),
    .b      (bus.B),
    .busy   (md_busy),
    .done   (md_done),
    .result (md_result),
    .div0   (md_div0)
  );
`else
  assign is_md = 1'b0;
`endif

  always_comb begin
    sub          = (bus.ALU_Ctr == OP_SUB);
    bo           = bus.B ^ {WIDTH{sub}};
    {carry, sum} = {1'b0, bus.A} + {1'b0, bo} + {{WIDTH{1'b0}}, sub};
    amt          = bus.B[SHW-1:0];
    alu_res      = '0;
    alu_co       = 1'b0;
    alu_ovf      = 1'b0;
    alu_ill      = 1'b0;
    case (bus.ALU_Ctr)
      OP_AND:  alu_res = bus.A & bus.B;
      OP_OR:   alu_res = bus.A | bus.B;
      OP_XOR:  alu_res = bus.A ^ bus.B;
      OP_NOR:  alu_res = ~(bus.A | bus.B);
      OP_NAND: alu_res = ~(bus.A & bus.B);
      OP_ADD, OP_SUB: begin
        alu_res = sum;
        alu_co  = carry;
        alu_ovf = add_sub_ovf(bus.A[WIDTH-1], bo[WIDTH-1], sum[WIDTH-1]);
      end
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (bus.A < bus.B)};
      OP_SLL:  alu_res = bus.A << amt;
      OP_SRL:  alu_res = bus.A >> amt;
      OP_SRA:  alu_res = $unsigned($signed(bus.A) >>> amt);
      default: alu_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    co_d    = co_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    ill_d   = ill_q;
    case (state_q)
      S_IDLE: begin
        if (accept && is_md) begin
          state_d = S_BUSY;
        end else if (accept) begin
          res_d   = alu_res;
          co_d    = alu_co;
          zero_d  = (alu_res == '0);
          ovf_d   = alu_ovf;
          ill_d   = alu_ill;
          state_d = S_DONE;
        end
      end
      S_BUSY: begin
`ifdef ALU_MULDIV_EN
        if (md_done) begin
          res_d   = md_result;
          co_d    = 1'b0;
          zero_d  = (md_result == '0);
          ovf_d   = md_div0;
          ill_d   = 1'b0;
          state_d = S_DONE;
        end else if (!md_busy) begin
          state_d = S_IDLE;
        end
`else
        state_d = S_IDLE;
`endif
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      res_q   <= '0;
      co_q    <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      co_q    <= co_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      ill_q   <= ill_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.res       = res_q;
  assign bus.Co        = co_q;
  assign bus.zero      = zero_q;
  assign bus.overflow  = ovf_q;
  assign bus.illegal   = ill_q;

endmodule

// File: tb/tb_seq_alu_param.sv
// tb/tb_seq_alu_param.sv - directed vector bench for seq_alu_param (expectations follow ALU_MULDIV_EN)
module tb_seq_alu_param;
  import alu_pkg::*;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        co;
    logic        zero;
    logic        ovf;
    logic        ill;
    int          lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];

  seq_alu_param_if #(.WIDTH(32)) bus ();

  seq_alu_param #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.in_valid = 1'b1;
    bus.ALU_Ctr  = op;
    bus.A        = a;
    bus.B        = b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic release_out();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".in_ready"},  bus.in_ready,  1);
    chk({tag, ".out_valid"}, bus.out_valid, 0);
    chk({tag, ".res"},       bus.res,       0);
    chk({tag, ".Co"},        bus.Co,        0);
    chk({tag, ".zero"},      bus.zero,      0);
    chk({tag, ".overflow"},  bus.overflow,  0);
    chk({tag, ".illegal"},   bus.illegal,   0);
  endtask

  initial begin
    int lat;
    int seen;

    vecs.push_back('{OP_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1'b1, 1'b0, 1});
    vecs.push_back('{OP_SUB,  32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0, 1});
    vecs.push_back('{OP_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{OP_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0, 1});
    vecs.push_back('{OP_SLT,  32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0, 1});
    vecs.push_back('{OP_SLTU, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{OP_SRA,  32'h80000000, 32'h00000024, 32'hF8000000, 1'b0, 1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{OP_SLL,  32'h00000001, 32'h0000001F, 32'h80000000, 1'b0, 1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{OP_SRL,  32'h80000000, 32'h00000021, 32'h40000000, 1'b0, 1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{OP_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{OP_OR,   32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 1'b0, 1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{OP_XOR,  32'hFFFF0000, 32'hFF00FF00, 32'h00FFFF00, 1'b0, 1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{OP_NOR,  32'h0F0F0F0F, 32'hF0F0F0F0, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0, 1});
    vecs.push_back('{OP_NAND, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0, 1});
    vecs.push_back('{OP_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0, 1});
    vecs.push_back('{OP_SUB,  32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{OP_SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b1, 1'b0, 1});
    vecs.push_back('{OP_ILL,  32'h00000005, 32'h00000003, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b1, 1});
`ifdef ALU_MULDIV_EN
    vecs.push_back('{OP_MUL,  32'h00010001, 32'h00010001, 32'h00020001, 1'b0, 1'b0, 1'b0, 1'b0, 33});
    vecs.push_back('{OP_DIVU, 32'd100,      32'd7,        32'd14,       1'b0, 1'b0, 1'b0, 1'b0, 33});
    vecs.push_back('{OP_REMU, 32'd100,      32'd7,        32'd2,        1'b0, 1'b0, 1'b0, 1'b0, 33});
    vecs.push_back('{OP_DIVU, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 1'b0, 33});
    vecs.push_back('{OP_REMU, 32'd5,        32'd0,        32'd5,        1'b0, 1'b0, 1'b1, 1'b0, 33});
    vecs.push_back('{OP_DIVU, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd1,        1'b0, 1'b0, 1'b0, 1'b0, 33});
`else
    vecs.push_back('{OP_MUL,  32'h00010001, 32'h00010001, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b1, 1});
    vecs.push_back('{OP_DIVU, 32'd100,      32'd7,        32'h00000000, 1'b0, 1'b1, 1'b0, 1'b1, 1});
    vecs.push_back('{OP_REMU, 32'd100,      32'd7,        32'h00000000, 1'b0, 1'b1, 1'b0, 1'b1, 1});
`endif

    bus.in_valid  = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.ALU_Ctr   = OP_AND;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk_reset_outputs("reset");

    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_out(lat);
      chk($sformatf("v%0d.res", i),      bus.res,      vecs[i].res);
      chk($sformatf("v%0d.Co", i),       bus.Co,       vecs[i].co);
      chk($sformatf("v%0d.zero", i),     bus.zero,     vecs[i].zero);
      chk($sformatf("v%0d.overflow", i), bus.overflow, vecs[i].ovf);
      chk($sformatf("v%0d.illegal", i),  bus.illegal,  vecs[i].ill);
      chk($sformatf("v%0d.latency", i),  lat,          vecs[i].lat);
      release_out();
    end

    // Hold the result with out_ready low while a competing request is offered.
`ifdef ALU_MULDIV_EN
    issue(OP_MUL, 32'h00010001, 32'h00010001);
`else
    issue(OP_ADD, 32'h00001234, 32'h00000001);
`endif
    wait_out(lat);
    bus.in_valid = 1'b1;
    bus.ALU_Ctr  = OP_OR;
    bus.A        = 32'hAAAA0000;
    bus.B        = 32'h00005555;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
`ifdef ALU_MULDIV_EN
      chk($sformatf("hold%0d.res", k), bus.res, 32'h00020001);
`else
      chk($sformatf("hold%0d.res", k), bus.res, 32'h00001235);
`endif
      chk($sformatf("hold%0d.out_valid", k), bus.out_valid, 1);
      chk($sformatf("hold%0d.in_ready", k),  bus.in_ready,  0);
    end
    bus.in_valid = 1'b0;
    release_out();
    chk("after_hold.out_valid", bus.out_valid, 0);
    chk("after_hold.in_ready",  bus.in_ready,  1);

    // Reset in the middle of an operation must drop it without delivery.
`ifdef ALU_MULDIV_EN
    issue(OP_MUL, 32'h00010001, 32'h00010001);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    chk("midop.out_valid", bus.out_valid, 0);
`else
    issue(OP_ILL, 32'h00000005, 32'h00000003);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("midop.out_valid", bus.out_valid, 1);
    chk("midop.illegal",   bus.illegal,   1);
`endif
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk_reset_outputs("abort");
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen++;
    end
    chk("abort.no_delivery", seen, 0);

    issue(OP_ADD, 32'd2, 32'd3);
    wait_out(lat);
    chk("post_reset.res",     bus.res,      32'd5);
    chk("post_reset.latency", lat,          1);
    chk("post_reset.zero",    bus.zero,     0);
    chk("post_reset.illegal", bus.illegal,  0);
    release_out();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_alu_param.md
Name: seq_alu_param

Overview:
- Parametrised, handshaked successor of the single-cycle 32-bit ALU; drop-in execution unit for the multi-cycle CPU datapath.
- Width is generic and the opcode space grows to 4 bits, adding shifts, unsigned compare and iterative multiply/divide.
- Operands are captured on a valid/ready handshake; results and flags are returned registered on a second valid/ready handshake.

Parameters:
- WIDTH, 32, datapath width; power of two, 8..64.
- SHW, $clog2(WIDTH), shift-amount width (derived; not overridden).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active-low
- in_valid  in  1  operands/opcode valid
- in_ready  out  1  unit can accept an operation
- A  in  WIDTH  operand A
- B  in  WIDTH  operand B
- ALU_Ctr  in  4  opcode
- out_valid  out  1  result valid
- out_ready  in  1  consumer takes result
- res  out  WIDTH  result
- Co  out  1  carry out (ADD/SUB only)
- zero  out  1  res == 0
- overflow  out  1  signed overflow (ADD/SUB); divide-by-zero (DIVU/REMU)
- illegal  out  1  opcode unsupported

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Opcodes:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 XOR
  - 0100 NOR, 0101 NAND, 0110 SUB, 0111 SLT (signed)
  - 1000 SLTU, 1001 SLL, 1010 SRL, 1011 SRA
  - 1100 MUL (low WIDTH bits), 1101 DIVU, 1110 REMU
  - 1111 illegal
- States: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - in_valid&&in_ready captures A, B and ALU_Ctr.
  - Single-cycle or illegal op: result and flags are registered and the FSM goes to DONE; out_valid rises the next cycle (latency 1).
  - MUL/DIVU/REMU: go to BUSY with iteration counter = WIDTH-1.
- BUSY:
  - in_ready=0.
  - One shift-add (MUL) or restoring-subtract (DIVU/REMU) step per cycle.
  - When counter==0, go to DONE. Total latency is WIDTH+1 cycles from accept to out_valid.
- DONE:
  - out_valid=1; res and flags are held stable while out_ready=0.
  - out_ready=1 returns to IDLE next cycle; in_ready=0 during DONE, so peak throughput is 1 op per 2 cycles.
- ADD/SUB arithmetic:
  - Sum = A + (B ^ {WIDTH{sub}}) + sub.
  - Co = carry out of bit WIDTH-1; for SUB, Co=1 means no borrow.
  - overflow = (A[msb]==Bo[msb]) && (Sum[msb]!=A[msb]).
- SLT/SLTU: res = {0..0, lt}. SLT is a signed compare; SLTU is unsigned.
- Shifts: amount = B[SHW-1:0]; SRA replicates A[msb].
- DIVU/REMU with B==0: quotient = all ones, remainder = A, overflow=1.
- MUL: overflow=0; upper product bits are discarded.
- zero: valid for every op.
- Co and overflow: 0 for every op not listed above.
- illegal: opcode 1111 gives res=0, zero=1, illegal=1, delivered with normal latency 1.
- Reset (rst_n=0 at a clk edge):
  - State=IDLE; in_ready=1 from the first cycle after reset; out_valid=0.
  - res=0, Co=0, zero=0, overflow=0, illegal=0; counter=0.
  - Reset aborts a BUSY operation or a DONE result; nothing is delivered.
- in_valid high while in_ready=0 is ignored; the producer must hold its request.

Optional Feature:
- Macro: ALU_MULDIV_EN.
- Defined: MUL/DIVU/REMU are implemented as above.
- Undefined:
  - Opcodes 1100–1110 behave like 1111: illegal=1, res=0, latency 1.
  - No iterative datapath or counter is synthesised; BUSY is unreachable.

Decomposition:
- Package alu_pkg holds:
  - opcode localparams (OP_AND..OP_REMU, OP_ILL);
  - FSM state encoding (S_IDLE, S_BUSY, S_DONE);
  - a function for the ADD/SUB overflow expression.
- Sub-module alu_muldiv_iter:
  - WIDTH-parametrised iterative shift-add multiplier / restoring divider;
  - ports: start, op, a, b, busy, done, result, div0;
  - compiled only under ALU_MULDIV_EN.
- Top-level keeps the combinational ops, the flags, the FSM and the output registers.

Test Plan:
- WIDTH=32, ADD A=0x7FFFFFFF B=1 -> res=0x80000000, overflow=1, Co=0, zero=0, out_valid 1 cycle after accept.
- SUB A=5 B=5 -> res=0, zero=1, Co=1. SLT A=0xFFFFFFFF B=1 -> res=1; SLTU with the same operands -> res=0.
- SRA A=0x80000000 B=0x24 (amount 4) -> res=0xF8000000; SLL A=1 B=31 -> res=0x80000000.
- MUL A=0x10001 B=0x10001 -> res=0x00020001, out_valid at cycle 33. Hold out_ready=0 for 5 cycles -> res stable, in_ready=0.
- DIVU A=100 B=7 -> res=14; REMU -> res=2; DIVU B=0 -> res=0xFFFFFFFF, overflow=1. Rebuild without ALU_MULDIV_EN -> illegal=1, res=0.
- Assert rst_n=0 mid-BUSY (cycle 10 of MUL) -> next cycle state IDLE, out_valid=0, in_ready=1, all outputs 0; the next ADD 2+3 -> res=5.
